prog_clk_divider: RTL and testbench

Multi-channel runtime-programmable clock divider producing NUM_CH independent divided clock-enable waveforms with programmable period and duty cycle from one system clock. Each channel is reconfigured through a shared valid/ready configuration port, and new settings take effect glitch-free at the channel's next period boundary. A global sync input phase-aligns all enabled channels. It sits between the board clock and the slow peripherals (display scan, debouncers, LED blink) that today each carry a fixed divide-by-N counter.

---
 rtl/clkdiv_pkg.sv | 13 +
 rtl/clkdiv_channel.sv | 83 ++++++++
 rtl/prog_clk_divider.sv | 80 ++++++++
 tb/tb_prog_clk_divider.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and configuration payload for the programmable clock divider.
package clkdiv_pkg;

   localparam int unsigned CLKDIV_MIN_PERIOD = 2;
   localparam int unsigned CH_IDX_W          = 4;
   localparam int unsigned CLKDIV_CNT_W      = 16;

   typedef struct packed {
      logic [CLKDIV_CNT_W-1:0] period;
      logic [CLKDIV_CNT_W-1:0] high;
   } clkdiv_cfg_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active and shadow period/high, registered outputs.
// Optional macro CLKDIV_TICK_EN builds the per-period tick output; otherwise tick is tied low.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned RST_PERIOD = 2,
   parameter int unsigned RST_HIGH   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        sync,
   input  logic        load,
   input  clkdiv_cfg_t cfg,
   output logic        pend,
   output logic        div_clk,
   output logic        tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] per;
   logic [CNT_W-1:0] per_nx;
   logic [CNT_W-1:0] high;
   logic [CNT_W-1:0] high_nx;
   logic [CNT_W-1:0] per_sh;
   logic [CNT_W-1:0] high_sh;
   logic             run;
   logic             restart;
   logic             boundary;
   logic             apply;

   // A period boundary is a wrap, an enable rise, a sync, or simply being disabled.
   always_comb begin
      restart  = en && (!run || sync || (cnt == per - CNT_W'(1)));
      boundary = !en || restart;
      apply    = pend && boundary;
      per_nx   = apply ? per_sh : per;
      high_nx  = apply ? high_sh : high;
      cnt_nx   = boundary ? '0 : cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run     <= 1'b0;
         cnt     <= '0;
         per     <= CNT_W'(RST_PERIOD);
         high    <= CNT_W'(RST_HIGH);
         per_sh  <= CNT_W'(RST_PERIOD);
         high_sh <= CNT_W'(RST_HIGH);
         pend    <= 1'b0;
         div_clk <= 1'b0;
      end else begin
         run     <= en;
         cnt     <= cnt_nx;
         per     <= per_nx;
         high    <= high_nx;
         div_clk <= en && (cnt_nx < high_nx);
         // A load only happens while pend is clear, so it never collides with an apply.
         if (load) begin
            per_sh  <= CNT_W'(cfg.period);
            high_sh <= CNT_W'(cfg.high);
            pend    <= 1'b1;
         end else if (apply) begin
            pend    <= 1'b0;
         end
      end
   end

`ifdef CLKDIV_TICK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         tick <= 1'b0;
      end else begin
         tick <= en && (cnt_nx == '0);
      end
   end
`else
   assign tick = 1'b0;
`endif

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: config decode, ready mux, error flag, channel array.
// Optional macro CLKDIV_TICK_EN enables the per-channel tick outputs.
module prog_clk_divider
   import clkdiv_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned RST_PERIOD = 2,
   parameter int unsigned RST_HIGH   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_CH-1:0]   en,
   input  logic                sync,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_IDX_W-1:0] cfg_ch,
   input  logic [CNT_W-1:0]    cfg_period,
   input  logic [CNT_W-1:0]    cfg_high,
   output logic                cfg_err,
   output logic [NUM_CH-1:0]   div_clk,
   output logic [NUM_CH-1:0]   tick
);

   localparam int unsigned IDX_CMP_W = CH_IDX_W + 1;

   logic              in_range;
   logic              req_ok;
   logic              accept;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] load;
   clkdiv_cfg_t       req_cfg;

   // Request decode; out-of-range channels are always ready so they can be rejected.
   always_comb begin
      in_range  = IDX_CMP_W'(cfg_ch) < IDX_CMP_W'(NUM_CH);
      req_ok    = in_range && (cfg_period >= CNT_W'(CLKDIV_MIN_PERIOD)) &&
                  (cfg_high != '0) && (cfg_high < cfg_period);
      cfg_ready = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         if (cfg_ch == CH_IDX_W'(c)) begin
            cfg_ready = !pend[c];
         end
      end
      accept = cfg_valid && cfg_ready;
      load   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         load[c] = accept && req_ok && (cfg_ch == CH_IDX_W'(c));
      end
      req_cfg.period = CLKDIV_CNT_W'(cfg_period);
      req_cfg.high   = CLKDIV_CNT_W'(cfg_high);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= accept && !req_ok;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      clkdiv_channel #(
         .CNT_W      (CNT_W),
         .RST_PERIOD (RST_PERIOD),
         .RST_HIGH   (RST_HIGH)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .en      (en[c]),
         .sync    (sync),
         .load    (load[c]),
         .cfg     (req_cfg),
         .pend    (pend[c]),
         .div_clk (div_clk[c]),
         .tick    (tick[c])
      );
   end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: directed sequences, a vector table and random traffic
// compared against a phase-based behavioural model of each channel.
module tb_prog_clk_divider;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] en;
   logic              sync;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [3:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_period;
   logic [CNT_W-1:0]  cfg_high;
   logic              cfg_err;
   logic [NUM_CH-1:0] div_clk;
   logic [NUM_CH-1:0] tick;

   always #5 clk = ~clk;

   prog_clk_divider #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .sync       (sync),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_err    (cfg_err),
      .div_clk    (div_clk),
      .tick       (tick)
   );

   int tests = 0;
   int fails = 0;

   // Model: each channel has a phase within its current period and a one-deep pending setting.
   int                m_per [NUM_CH];
   int                m_high[NUM_CH];
   int                m_ph  [NUM_CH];
   bit                m_run [NUM_CH];
   bit                m_pend[NUM_CH];
   int                m_pper[NUM_CH];
   int                m_phigh[NUM_CH];
   logic [NUM_CH-1:0] exp_div;
   logic [NUM_CH-1:0] exp_tick;
   logic              exp_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_ready(input logic [3:0] ch);
      if (int'(ch) >= NUM_CH) return 1'b1;
      return !m_pend[ch];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_per[c] = 2; m_high[c] = 1; m_ph[c] = 0; m_run[c] = 0; m_pend[c] = 0;
      end
      exp_div = '0; exp_tick = '0; exp_err = 1'b0;
   endtask

   task automatic model_edge();
      bit acc, ok, restart;
      acc = cfg_valid && model_ready(cfg_ch);
      ok  = (int'(cfg_ch) < NUM_CH) && (int'(cfg_period) >= 2) && (int'(cfg_high) >= 1) &&
            (int'(cfg_high) < int'(cfg_period));
      exp_err = acc && !ok;
      for (int c = 0; c < NUM_CH; c++) begin
         restart = en[c] && (sync || !m_run[c] || (m_ph[c] == m_per[c] - 1));
         if (!en[c] || restart) begin
            if (m_pend[c]) begin
               m_per[c] = m_pper[c]; m_high[c] = m_phigh[c]; m_pend[c] = 0;
            end
            m_ph[c] = 0;
         end else begin
            m_ph[c] = m_ph[c] + 1;
         end
         exp_div[c] = en[c] && (m_ph[c] < m_high[c]);
`ifdef CLKDIV_TICK_EN
         exp_tick[c] = en[c] && (m_ph[c] == 0);
`else
         exp_tick[c] = 1'b0;
`endif
         m_run[c] = en[c];
         if (acc && ok && (int'(cfg_ch) == c)) begin
            m_pper[c] = int'(cfg_period); m_phigh[c] = int'(cfg_high); m_pend[c] = 1;
         end
      end
   endtask

   // One clock: check ready, cross the edge, update model, check registered outputs.
   task automatic cycle();
      #1;
      if (cfg_valid) chk("cfg_ready", 32'(cfg_ready), 32'(model_ready(cfg_ch)));
      @(posedge clk);
      if (reset) model_reset();
      else model_edge();
      #1;
      chk("div_clk", 32'(div_clk), 32'(exp_div));
      chk("tick", 32'(tick), 32'(exp_tick));
      chk("cfg_err", 32'(cfg_err), 32'(exp_err));
   endtask

   task automatic send(input int ch, input int per, input int hi);
      cfg_valid = 1'b1; cfg_ch = 4'(ch); cfg_period = CNT_W'(per); cfg_high = CNT_W'(hi);
   endtask

   typedef struct {
      int ch;
      int period;
      int high;
      bit exp_err;
   } vec_t;

   vec_t vecs[6];
   bit   pat2[4];
   bit   pat5[9];
   bit   pat3[6];
   int   stalls;
   bit   done;

   initial begin
      vecs[0] = '{ch: 1, period: 1, high: 0, exp_err: 1'b1};
      vecs[1] = '{ch: 1, period: 5, high: 0, exp_err: 1'b1};
      vecs[2] = '{ch: 1, period: 5, high: 5, exp_err: 1'b1};
      vecs[3] = '{ch: 7, period: 5, high: 2, exp_err: 1'b1};
      vecs[4] = '{ch: 15, period: 9, high: 3, exp_err: 1'b1};
      vecs[5] = '{ch: 3, period: 2, high: 1, exp_err: 1'b0};
      pat2 = '{1, 0, 1, 0};
      pat5 = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
      pat3 = '{1, 0, 1, 1, 1, 0};

      model_reset();
      reset = 1'b1; en = '0; sync = 1'b0; cfg_valid = 1'b0;
      cfg_ch = '0; cfg_period = '0; cfg_high = '0;
      cycle(); cycle();
      chk("rst_div", 32'(div_clk), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);

      // Default period 2 / high 1 after reset
      reset = 1'b0; en = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("ch0_default", 32'(div_clk[0]), 32'(pat2[i]));
      end

      // Reconfigure ch1 to 5/2 while it runs at period 2
      en = 4'b0011;
      cycle();
      send(1, 5, 2);
      cycle();
      cfg_valid = 1'b0;
      chk("ch1_old_tail", 32'(div_clk[1]), 32'(pat5[0]));
      for (int i = 1; i < 9; i++) begin
         cycle();
         chk("ch1_new5", 32'(div_clk[1]), 32'(pat5[i]));
      end

      // Invalid and out-of-range requests
      foreach (vecs[i]) begin
         send(vecs[i].ch, vecs[i].period, vecs[i].high);
         cycle();
         chk("tbl_err", 32'(cfg_err), 32'(vecs[i].exp_err));
         cfg_valid = 1'b0;
         cycle();
         chk("tbl_err_clear", 32'(cfg_err), 32'd0);
      end

      // Back-to-back requests to ch2: the second stalls until the first is applied
      en = 4'b0111;
      cycle();
      send(2, 100, 50);
      cycle();
      send(2, 100, 30);
      stalls = 0; done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         #1;
         if (cfg_ready) done = 1'b1;
         else stalls++;
         cycle();
      end
      cfg_valid = 1'b0;
      chk("bp_accepted", 32'(done), 32'd1);
      chk("bp_stalls", 32'(stalls), 32'd1);

      // Phase alignment with sync; ch3 gets a config on the sync edge itself
      send(0, 3, 1); cycle();
      send(1, 7, 3); cycle();
      cfg_valid = 1'b0; en = 4'b1111;
      for (int i = 0; i < 10; i++) cycle();
      sync = 1'b1; send(3, 4, 3);
      cycle();
      sync = 1'b0; cfg_valid = 1'b0;
      chk("sync_all_high", 32'(div_clk), 32'hf);
      chk("sync_ch3", 32'(div_clk[3]), 32'(pat3[0]));
      for (int k = 1; k < 14; k++) begin
         cycle();
         chk("sync_ch0", 32'(div_clk[0]), 32'((k % 3) < 1));
         chk("sync_ch1", 32'(div_clk[1]), 32'((k % 7) < 3));
         if (k < 6) chk("sync_ch3", 32'(div_clk[3]), 32'(pat3[k]));
      end

      // Reset mid-period with a pending config on ch1
      send(1, 9, 4); cycle();
      cfg_valid = 1'b0; reset = 1'b1;
      cycle();
      chk("midrst_div", 32'(div_clk), 32'd0);
      chk("midrst_tick", 32'(tick), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("midrst_ch1", 32'(div_clk[1]), 32'(pat2[i]));
      end

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 799) == 0);
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 63) == 0) en[c] = ~en[c];
         end
         sync = ($urandom_range(0, 39) == 0);
         cfg_valid = ($urandom_range(0, 2) == 0);
         cfg_ch = 4'($urandom_range(0, 5));
         cfg_period = CNT_W'($urandom_range(0, 9));
         cfg_high = CNT_W'($urandom_range(0, 9));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
